reconf_fir_filter: RTL and testbench

Reconfigurable time-multiplexed FIR filter with up to 40 taps. It holds 16-bit coefficients in four internal 10-word coefficient banks loaded through a simple write port, and keeps a 40-deep delay line of 3-bit signed input samples. Four parallel multiply-accumulate lanes, one per bank, process the taps over 10 clock cycles. It sits between a 3-bit sample source at 600 kHz and downstream 16-bit processing, all on the 12 MHz system clock.

---
 rtl/reconf_fir_filter.sv | 189 ++++++++++++++++++
 tb/tb_reconf_fir_filter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/reconf_fir_filter.sv
// Reconfigurable time-multiplexed FIR filter: up to 40 taps, four 10-word coefficient
// banks, four MAC lanes sweeping their bank over 10 cycles, saturated 16-bit output.
module reconf_fir_filter (
    input  logic        iClk12M,
    input  logic        iRsn,
    input  logic        iEnSample600k,
    input  logic        iCoeffUpdateFlag,
    input  logic [2:0]  iFirIn,
    input  logic [5:0]  iNumOfCoeff,
    input  logic [5:0]  iAddrRam,
    input  logic [15:0] iWrDtRam,
    output logic [15:0] oFirOut
);

    localparam int unsigned NumTaps   = 40;
    localparam int unsigned NumBanks  = 4;
    localparam int unsigned BankDepth = 10;

    typedef enum logic [1:0] {StIdle, StRun, StSum} state_e;

    state_e       state_q, state_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [5:0]   num_q, num_d;
    logic [2:0]   taps_q [NumTaps];
    logic [2:0]   taps_d [NumTaps];
    logic [15:0]  coeff_q [NumBanks][BankDepth];
    logic [15:0]  coeff_d [NumBanks][BankDepth];
    logic [15:0]  rd_q [NumBanks];
    logic [15:0]  rd_d [NumBanks];
    logic [3:0]   rd_j_q, rd_j_d;
    logic         rd_vld_q, rd_vld_d;
    logic [23:0]  acc_q [NumBanks];
    logic [23:0]  acc_d [NumBanks];
    logic [15:0]  out_q, out_d;

    logic [1:0]   wr_bank;
    logic [3:0]   wr_local;
    logic [5:0]   tap_idx [NumBanks];
    logic [18:0]  prod [NumBanks];
    logic signed [25:0] sum_s;
    logic [15:0]  sat;

    // Coefficient write port: address split into bank and local word, 40..63 dropped
    always_comb begin
        coeff_d  = coeff_q;
        wr_bank  = 2'd0;
        wr_local = 4'd0;
        if (iAddrRam < 6'd10) begin
            wr_bank  = 2'd0;
            wr_local = iAddrRam[3:0];
        end else if (iAddrRam < 6'd20) begin
            wr_bank  = 2'd1;
            wr_local = 4'(iAddrRam - 6'd10);
        end else if (iAddrRam < 6'd30) begin
            wr_bank  = 2'd2;
            wr_local = 4'(iAddrRam - 6'd20);
        end else begin
            wr_bank  = 2'd3;
            wr_local = 4'(iAddrRam - 6'd30);
        end
        if (iCoeffUpdateFlag && (iAddrRam < 6'(NumTaps))) begin
            coeff_d[wr_bank][wr_local] = iWrDtRam;
        end
    end

    // Per-lane product of the registered bank word and its tap; taps at or beyond N give 0
    always_comb begin
        for (int b = 0; b < NumBanks; b++) begin
            tap_idx[b] = 6'(b * BankDepth) + {2'b00, rd_j_q};
            if (tap_idx[b] < num_q) begin
                prod[b] = {{16{taps_q[tap_idx[b]][2]}}, taps_q[tap_idx[b]]}
                        * {{3{rd_q[b][15]}}, rd_q[b]};
            end else begin
                prod[b] = '0;
            end
        end
    end

    // Lane sum widened to 26 bits, then clamped to the signed 16-bit range
    always_comb begin
        sum_s = 26'sd0;
        for (int b = 0; b < NumBanks; b++) begin
            sum_s = sum_s + $signed({{2{acc_q[b][23]}}, acc_q[b]});
        end
        if (sum_s > 26'sd32767) begin
            sat = 16'h7FFF;
        end else if (sum_s < -26'sd32768) begin
            sat = 16'h8000;
        end else begin
            sat = sum_s[15:0];
        end
    end

    // Controller: accept sample, issue 10 bank reads, accumulate one cycle later, sum
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        num_d    = num_q;
        taps_d   = taps_q;
        rd_d     = rd_q;
        rd_j_d   = rd_j_q;
        rd_vld_d = 1'b0;
        acc_d    = acc_q;
        out_d    = out_q;
        if (iCoeffUpdateFlag) begin
            // Load mode aborts any computation; delay line and output are kept
            state_d = StIdle;
            cnt_d   = 4'd0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (iEnSample600k) begin
                        for (int i = NumTaps - 1; i > 0; i--) begin
                            taps_d[i] = taps_q[i-1];
                        end
                        taps_d[0] = iFirIn;
                        num_d     = (iNumOfCoeff > 6'(NumTaps)) ? 6'(NumTaps) : iNumOfCoeff;
                        for (int b = 0; b < NumBanks; b++) begin
                            acc_d[b] = '0;
                        end
                        cnt_d   = 4'd0;
                        state_d = StRun;
                    end
                end
                StRun: begin
                    if (cnt_q < 4'(BankDepth)) begin
                        for (int b = 0; b < NumBanks; b++) begin
                            rd_d[b] = coeff_q[b][cnt_q];
                        end
                        rd_j_d   = cnt_q;
                        rd_vld_d = 1'b1;
                    end
                    if (rd_vld_q) begin
                        for (int b = 0; b < NumBanks; b++) begin
                            acc_d[b] = acc_q[b] + {{5{prod[b][18]}}, prod[b]};
                        end
                    end
                    // Extra count covers the last accumulate behind the read pipeline
                    if (cnt_q == 4'(BankDepth)) begin
                        state_d = StSum;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
                StSum: begin
                    out_d   = sat;
                    state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // State registers, all cleared by the asynchronous reset
    always_ff @(posedge iClk12M or negedge iRsn) begin
        if (!iRsn) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            num_q    <= '0;
            rd_j_q   <= '0;
            rd_vld_q <= 1'b0;
            out_q    <= '0;
            for (int i = 0; i < NumTaps; i++) begin
                taps_q[i] <= '0;
            end
            for (int b = 0; b < NumBanks; b++) begin
                rd_q[b]  <= '0;
                acc_q[b] <= '0;
                for (int j = 0; j < BankDepth; j++) begin
                    coeff_q[b][j] <= '0;
                end
            end
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            num_q    <= num_d;
            rd_j_q   <= rd_j_d;
            rd_vld_q <= rd_vld_d;
            out_q    <= out_d;
            taps_q   <= taps_d;
            rd_q     <= rd_d;
            acc_q    <= acc_d;
            coeff_q  <= coeff_d;
        end
    end

    assign oFirOut = out_q;

endmodule

// File: tb/tb_reconf_fir_filter.sv
`timescale 1ns/1ps
// Bench for reconf_fir_filter: behavioural convolution model plus directed and random stimulus.
module tb_reconf_fir_filter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en = 1'b0;
    logic        flag = 1'b0;
    logic [2:0]  fir_in = '0;
    logic [5:0]  num = '0;
    logic [5:0]  addr = '0;
    logic [15:0] wr = '0;
    logic [15:0] out;

    int checks = 0;
    int errors = 0;

    always #42 clk = ~clk;

    reconf_fir_filter dut (
        .iClk12M          (clk),
        .iRsn             (rst_n),
        .iEnSample600k    (en),
        .iCoeffUpdateFlag (flag),
        .iFirIn           (fir_in),
        .iNumOfCoeff      (num),
        .iAddrRam         (addr),
        .iWrDtRam         (wr),
        .oFirOut          (out)
    );

    // Reference model: coefficient table, sample history, and a 12-clock result delay
    int          mc [40];
    int          hist [40];
    int          pend = 0;
    int          pend_val = 0;
    logic [15:0] exp_out = '0;

    task automatic model_step();
        int n;
        int y;
        if (!rst_n) begin
            for (int k = 0; k < 40; k++) begin
                mc[k]   = 0;
                hist[k] = 0;
            end
            pend    = 0;
            exp_out = '0;
        end else if (flag) begin
            if (addr < 6'd40) mc[addr] = int'($signed(wr));
            pend = 0;
        end else if (pend > 0) begin
            pend--;
            if (pend == 0) exp_out = 16'(pend_val);
        end else if (en) begin
            for (int k = 39; k > 0; k--) hist[k] = hist[k-1];
            hist[0] = int'($signed(fir_in));
            n = (num > 6'd40) ? 40 : int'(num);
            y = 0;
            for (int k = 0; k < n; k++) y += mc[k] * hist[k];
            if (y > 32767) y = 32767;
            if (y < -32768) y = -32768;
            pend_val = y;
            pend     = 12;
        end
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        model_step();
    end

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, got, expv);
        end
    endtask

    // Continuous comparison against the model away from the active edge
    initial forever begin
        @(negedge clk);
        check("stream", out, exp_out);
    end

    task automatic write_coeff(input int a, input int d);
        @(negedge clk);
        flag = 1'b1;
        addr = 6'(a);
        wr   = 16'(d);
    endtask

    task automatic end_load();
        @(negedge clk);
        flag = 1'b0;
        addr = '0;
        wr   = '0;
    endtask

    // One strobe, then idle so that successive strobes are 20 clocks apart
    task automatic strobe(input int s);
        @(negedge clk);
        en     = 1'b1;
        fir_in = 3'(s);
        @(negedge clk);
        en     = 1'b0;
        fir_in = '0;
        repeat (18) @(negedge clk);
    endtask

    task automatic flush();
        for (int i = 0; i < 40; i++) strobe(0);
    endtask

    initial begin
        rst_n = 1'b0;
        #100;
        rst_n = 1'b1;
        check("reset_out", out, 16'h0000);
        for (int i = 0; i < 3; i++) strobe(0);
        check("zero_in", out, 16'h0000);

        // Impulse response with c[k]=k+1
        for (int k = 0; k < 40; k++) write_coeff(k, k + 1);
        write_coeff(45, 16'h1234);
        end_load();
        num = 6'd40;
        strobe(1);
        check("impulse_first", out, 16'd1);
        for (int i = 1; i < 40; i++) strobe(0);
        check("impulse_last", out, 16'd40);
        strobe(0);
        check("impulse_after", out, 16'h0000);

        // Abort: load mode raised at E5 keeps the old output and the delay line
        @(negedge clk);
        en     = 1'b1;
        fir_in = 3'd1;
        @(negedge clk);
        en     = 1'b0;
        fir_in = '0;
        repeat (3) @(negedge clk);
        flag = 1'b1;
        addr = 6'd45;
        wr   = 16'h5555;
        repeat (3) @(negedge clk);
        flag = 1'b0;
        addr = '0;
        repeat (20) @(negedge clk);
        check("abort_hold", out, 16'h0000);
        strobe(0);
        check("abort_keeps_line", out, 16'd2);
        flush();

        // Negative impulse
        strobe(-4);
        check("neg_first", out, 16'hFFFC);
        for (int i = 1; i < 40; i++) strobe(0);
        check("neg_last", out, 16'hFF60);
        strobe(0);
        check("neg_after", out, 16'h0000);

        // Tap count N=10 then N=0
        num = 6'd10;
        strobe(1);
        for (int i = 1; i < 10; i++) strobe(0);
        check("n10_last", out, 16'd10);
        strobe(0);
        check("n10_after", out, 16'h0000);
        num = 6'd0;
        strobe(1);
        check("n0", out, 16'h0000);
        strobe(3);
        num = 6'd63;

        // Saturation
        for (int k = 0; k < 40; k++) write_coeff(k, 16'h7FFF);
        end_load();
        for (int i = 0; i < 41; i++) strobe(3);
        check("sat_pos", out, 16'h7FFF);
        for (int i = 0; i < 41; i++) strobe(-4);
        check("sat_neg", out, 16'h8000);

        // Random coefficients, strobes, load pulses and tap counts
        for (int k = 0; k < 40; k++) write_coeff(k, int'($urandom_range(0, 65535)));
        end_load();
        num = 6'($urandom_range(0, 63));
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            en     = ($urandom_range(0, 7) == 0);
            fir_in = 3'($urandom_range(0, 7));
            flag   = ($urandom_range(0, 39) == 0);
            addr   = 6'($urandom_range(0, 63));
            wr     = 16'($urandom_range(0, 65535));
            if ($urandom_range(0, 31) == 0) num = 6'($urandom_range(0, 63));
        end
        @(negedge clk);
        en   = 1'b0;
        flag = 1'b0;
        repeat (20) @(negedge clk);

        // Asynchronous reset in the middle of a computation
        num = 6'd40;
        @(negedge clk);
        en     = 1'b1;
        fir_in = 3'd3;
        @(negedge clk);
        en     = 1'b0;
        repeat (4) @(negedge clk);
        #10 rst_n = 1'b0;
        #10 check("midrun_reset", out, 16'h0000);
        @(negedge clk);
        #10 rst_n = 1'b1;
        strobe(1);
        check("post_reset_zero_coeff", out, 16'h0000);
        write_coeff(0, 5);
        end_load();
        strobe(1);
        check("post_reset_c0", out, 16'd5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
